serial_sub: RTL

- Bit-serial two's-complement subtractor, the inverse operation of the team's structural full-adder datapath.
- Computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Uses a start/busy/done handshake so the ALU control logic can launch an operation and wait for the result.
- Reports unsigned borrow, signed overflow and zero flags with the result.

---
 rtl/serial_sub.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = a - b, LSB first.
// One full-subtractor cell is reused on every clock. The borrow between bit
// steps is held in a flop.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request pulse, sampled only in idle
//   a, b       minuend / subtrahend, captured when start is accepted
//   busy       high while bit steps are running
//   done       one-cycle pulse; diff and flags are valid from this cycle on
//   diff       a - b mod 2^WIDTH, held until the next accepted start
//   borrow_out unsigned borrow (a < b)
//   overflow   signed overflow of a - b
//   zero       diff == 0
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  // Operand sign bits are kept here because the shift registers lose them.
  logic             a_msb_q, b_msb_q;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q, zero_q;

  logic             accept;
  logic             last_step;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] res_next;

  assign accept    = (state_q == StIdle) && start;
  assign last_step = (state_q == StRun) && (cnt_q == CntLast);

  // Full-subtractor cell.
  always_comb begin
    d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_next  = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & br_q) | (b_sr_q[0] & br_q);
    // New bits enter at the MSB, so after WIDTH steps bit 0 ends up in res[0].
    res_next = {d_bit, res_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Bit-serial datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      a_sr_q  <= a;
      b_sr_q  <= b;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == StRun) begin
      a_sr_q <= a_sr_q >> 1;
      b_sr_q <= b_sr_q >> 1;
      res_q  <= res_next;
      br_q   <= br_next;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Result and flags load only on the final bit step, so nothing partial is
  // ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (last_step) begin
      diff_q     <= res_next;
      borrow_q   <= br_next;
      overflow_q <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
      zero_q     <= (res_next == '0);
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule
